// File: rtl/sd_block_fifo.sv
// rtl/sd_block_fifo.sv - SD sector staging FIFO with first-word-fall-through read and sticky error flags
module sd_block_fifo #(
  parameter int DATA_WIDTH = 8,
  parameter int ADDR_WIDTH = 10,
  parameter int BLOCK_SIZE = 512
) (
  input  logic                  i_s_clk,
  input  logic                  i_reset,
  input  logic                  i_push,
  input  logic [DATA_WIDTH-1:0] i_8_data_in,
  input  logic                  i_pop,
  input  logic                  i_clear_flags,
  output logic [DATA_WIDTH-1:0] o_8_data_out,
  output logic [ADDR_WIDTH:0]   o_data_count,
  output logic                  o_available,
  output logic                  o_full,
  output logic                  o_empty,
  output logic                  o_overflow,
  output logic                  o_underflow
);

  localparam int DEPTH = 1 << ADDR_WIDTH;
  localparam logic [ADDR_WIDTH:0] DEPTH_CNT = DEPTH[ADDR_WIDTH:0];
  localparam logic [ADDR_WIDTH:0] BLOCK_CNT = BLOCK_SIZE[ADDR_WIDTH:0];

  logic [DATA_WIDTH-1:0] mem [DEPTH];

  logic [ADDR_WIDTH-1:0] wr_ptr_q, wr_ptr_d;
  logic [ADDR_WIDTH-1:0] rd_ptr_q, rd_ptr_d;
  logic [ADDR_WIDTH:0]   count_q, count_d;
  logic                  overflow_q, overflow_d;
  logic                  underflow_q, underflow_d;

  logic push_ok;
  logic pop_ok;

  // Status flags are decoded only from the registered count so they change cleanly on the clock.
  assign o_data_count = count_q;
  assign o_empty      = (count_q == '0);
  assign o_full       = (count_q == DEPTH_CNT);
  assign o_available  = (count_q >= BLOCK_CNT);
  assign o_overflow   = overflow_q;
  assign o_underflow  = underflow_q;

  // Head of the queue is read combinationally so the oldest entry is always presented.
  assign o_8_data_out = mem[rd_ptr_q];

  // Accept decisions, pointer/count updates and sticky error flag next-state.
  always_comb begin
    pop_ok      = i_pop && !o_empty;
    // A pop in the same cycle frees a slot, so a full FIFO can still take a push.
    push_ok     = i_push && (!o_full || pop_ok);
    wr_ptr_d    = wr_ptr_q;
    rd_ptr_d    = rd_ptr_q;
    count_d     = count_q;
    overflow_d  = overflow_q && !i_clear_flags;
    underflow_d = underflow_q && !i_clear_flags;

    if (push_ok) wr_ptr_d = wr_ptr_q + 1'b1;
    if (pop_ok)  rd_ptr_d = rd_ptr_q + 1'b1;

    case ({push_ok, pop_ok})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase

    // A new error in the same cycle as a clear wins, so no event is lost.
    if (i_push && !push_ok) overflow_d  = 1'b1;
    if (i_pop && o_empty)   underflow_d = 1'b1;
  end

  // Control state register; reset is asynchronous so a mid-sector abort takes effect at once.
  always_ff @(posedge i_s_clk or posedge i_reset) begin
    if (i_reset) begin
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      count_q     <= '0;
      overflow_q  <= 1'b0;
      underflow_q <= 1'b0;
    end else begin
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      count_q     <= count_d;
      overflow_q  <= overflow_d;
      underflow_q <= underflow_d;
    end
  end

  // Storage array write; contents are deliberately not cleared by reset.
  always_ff @(posedge i_s_clk) begin
    if (push_ok) mem[wr_ptr_q] <= i_8_data_in;
  end

endmodule

// File: doc/sd_block_fifo.md
SD_BLOCK_FIFO -- requirements
Module: sd_block_fifo

Interface
REQ-001 Parameter DATA_WIDTH, default 8, byte width of each stored entry.
REQ-002 Parameter ADDR_WIDTH, default 10, log2 of the storage depth (DEPTH = 2^ADDR_WIDTH = 1024).
REQ-003 Parameter BLOCK_SIZE, default 512, entry count that constitutes one SD sector.
REQ-004 i_s_clk  input  1  SD-domain clock; all state updates occur on its rising edge.
REQ-005 i_reset  input  1  asynchronous, active-high reset.
REQ-006 i_push  input  1  write request, sampled on the rising edge.
REQ-007 i_8_data_in  input  DATA_WIDTH  write data, captured when a push is accepted.
REQ-008 i_pop  input  1  read request from the sector writer, sampled on the rising edge.
REQ-009 o_8_data_out  output  DATA_WIDTH  oldest stored entry (first-word-fall-through).
REQ-010 o_data_count  output  ADDR_WIDTH+1  current number of stored entries, 0..DEPTH.
REQ-011 o_available  output  1  high when o_data_count >= BLOCK_SIZE.
REQ-012 o_full / o_empty  output  1 each  count == DEPTH / count == 0.
REQ-013 o_overflow / o_underflow  output  1 each  sticky error flags.
REQ-014 i_clear_flags  input  1  synchronous clear of both sticky flags.

Function
REQ-015 Storage SHALL be a DEPTH x DATA_WIDTH array with ADDR_WIDTH-bit write and read pointers that wrap from DEPTH-1 to 0.
REQ-016 A push SHALL be accepted when i_push=1 and (o_full=0 or an accepted pop occurs in the same cycle); the entry is written at wr_ptr, and wr_ptr increments.
REQ-017 A pop SHALL be accepted when i_pop=1 and o_empty=0; rd_ptr increments; o_8_data_out shows the next entry from the following cycle.
REQ-018 o_8_data_out SHALL equal mem[rd_ptr] whenever o_empty=0, with zero latency from the pointer update; its value when empty is don't-care.
REQ-019 Write-to-read latency SHALL be one cycle: an entry pushed into an empty FIFO appears on o_8_data_out, and o_empty falls, on the next cycle.
REQ-020 o_data_count SHALL update every cycle: +1 on push only, -1 on pop only, unchanged when both or neither are accepted.
REQ-021 Simultaneous push and pop when full SHALL both be accepted; count stays DEPTH; o_overflow is not set.
REQ-022 Simultaneous push and pop when empty SHALL accept only the push; count becomes 1; o_underflow is set.
REQ-023 Push while full without an accepted pop SHALL be dropped; memory and pointers are unchanged; o_overflow is set.
REQ-024 Pop while empty SHALL be ignored; o_underflow is set.
REQ-025 o_available, o_full, and o_empty SHALL be decoded from the registered o_data_count and SHALL be glitch-free relative to i_s_clk.
REQ-026 Sticky flags SHALL remain set until i_clear_flags=1; when a clear and a new error event occur in the same cycle, the flag stays set.
REQ-027 BLOCK_SIZE consecutive pops issued after o_available=1 SHALL deliver exactly BLOCK_SIZE entries in push order with no gaps or duplicates.

Reset
REQ-028 While i_reset=1: wr_ptr=0, rd_ptr=0, o_data_count=0, o_empty=1, o_full=0, o_available=0, o_overflow=0, o_underflow=0.
REQ-029 Reset SHALL take effect immediately and asynchronously, including mid-sector; stored memory contents need not be cleared.
REQ-030 The first push SHALL be accepted on the first rising edge after i_reset deasserts.

Verification
REQ-031 Push 0x00..0xFF, then pop 256 entries -> o_8_data_out sequence 0x00..0xFF; count returns to 0; o_empty=1.
REQ-032 Push 511 entries -> o_available=0; 512th push -> o_available=1 on the next cycle; one pop -> o_available=0.
REQ-033 Fill to 1024 -> o_full=1; push 0xAA -> dropped, o_overflow=1; push+pop together -> count stays 1024, next pops show unchanged data order.
REQ-034 Pop while empty -> o_underflow=1, count stays 0; i_clear_flags -> o_underflow=0 next cycle.
REQ-035 Pointer wrap: run 3000 push/pop pairs with random gaps -> data order is preserved and count never exceeds 1024.
REQ-036 Assert i_reset with count=700 -> count=0, o_empty=1 immediately; a push after deassert reads back correctly.
